// File: rtl/fft_pkg.sv
// Shared helpers for the FFT chain: index math, bit reversal and the flat
// frame layout (imaginary words low, real words high).
package fft_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } buf_state_e;

    // Ceiling log2 for n >= 2; used for index widths.
    function automatic int fft_log2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int fft_bitrev(input int idx, input int nbits);
        int r;
        r = 0;
        for (int b = 0; b < nbits; b++) begin
            r = (r << 1) | ((idx >> b) & 1);
        end
        return r;
    endfunction

    function automatic int fft_real_word(input int n, input int i);
        return n + i;
    endfunction

    function automatic int fft_imag_word(input int i);
        return i;
    endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// One N-word real sample buffer with a FILL/FULL flag; the flag goes FULL on
// the completing write and back to FILL when the frame is acknowledged.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    localparam int IDX_W    = fft_log2(N_SAMPLES)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           wr_en_i,
    input  logic [IDX_W-1:0]               wr_idx_i,
    input  logic [BIT_WIDTH-1:0]           wr_data_i,
    input  logic                           last_i,
    input  logic                           send_ack_i,
    output logic                           full_o,
    output logic [BIT_WIDTH*N_SAMPLES-1:0] words_o
);

    buf_state_e           state_q, state_d;
    logic [BIT_WIDTH-1:0] mem_q [N_SAMPLES];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FILL;
            for (int i = 0; i < N_SAMPLES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (wr_en_i) begin
                mem_q[wr_idx_i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (wr_en_i && last_i) state_d = FULL;
            FULL:    if (send_ack_i)        state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    assign full_o = (state_q == FULL);

    always_comb begin
        words_o = '0;
        for (int i = 0; i < N_SAMPLES; i++) begin
            words_o[BIT_WIDTH*i +: BIT_WIDTH] = mem_q[i];
        end
    end

endmodule

// File: rtl/fft_input_deserializer.sv
// Serial-to-parallel front end of the FFT chain: gathers N real samples into a
// bit-reversed complex frame. Define FFT_DESER_DBUF_EN for ping-pong buffering.
module fft_input_deserializer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int N_SAMPLES  = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [BIT_WIDTH-1:0]               recv_msg,
    input  logic                               recv_val,
    output logic                               recv_rdy,
    output logic [2*BIT_WIDTH*N_SAMPLES-1:0]   send_msg,
    output logic                               send_val,
    input  logic                               send_rdy
);

    localparam int IDX_W   = fft_log2(N_SAMPLES);
    localparam int FRAME_W = BIT_WIDTH * N_SAMPLES;
`ifdef FFT_DESER_DBUF_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n
        $error("N_SAMPLES must be a power of two >= 2");
    end
    if (DECIMAL_PT >= BIT_WIDTH) begin : g_bad_pt
        $error("DECIMAL_PT must be smaller than BIT_WIDTH");
    end

    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   wr_idx;
    logic               recv_fire, send_fire, last;
    logic [NBUF-1:0]    wr_en, ack, full;
    logic [FRAME_W-1:0] buf_words [NBUF];
    logic [FRAME_W-1:0] rd_words;

    assign recv_fire = recv_val && recv_rdy;
    assign send_fire = send_val && send_rdy;
    assign last      = (cnt_q == {IDX_W{1'b1}});
    assign wr_idx    = IDX_W'(fft_bitrev(int'(cnt_q), IDX_W));
    // Power-of-two frame size lets the counter wrap to 0 on its own.
    assign cnt_d     = recv_fire ? cnt_q + 1'b1 : cnt_q;

`ifdef FFT_DESER_DBUF_EN
    logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;

    assign wr_sel_d = (recv_fire && last) ? ~wr_sel_q : wr_sel_q;
    assign rd_sel_d = send_fire ? ~rd_sel_q : rd_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // Filling and draining buffers always differ when both strobes fire.
    always_comb begin
        for (int g = 0; g < NBUF; g++) begin
            wr_en[g] = recv_fire && (wr_sel_q == 1'(g));
            ack[g]   = send_fire && (rd_sel_q == 1'(g));
        end
    end

    assign recv_rdy = !full[wr_sel_q];
    assign send_val = full[rd_sel_q];
    assign rd_words = buf_words[rd_sel_q];
`else
    assign wr_en[0] = recv_fire;
    assign ack[0]   = send_fire;
    assign recv_rdy = !full[0];
    assign send_val = full[0];
    assign rd_words = buf_words[0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < NBUF; g++) begin : g_buf
        fft_frame_buffer #(
            .BIT_WIDTH (BIT_WIDTH),
            .N_SAMPLES (N_SAMPLES)
        ) u_buf (
            .clk_i      (clk),
            .reset_i    (reset),
            .wr_en_i    (wr_en[g]),
            .wr_idx_i   (wr_idx),
            .wr_data_i  (recv_msg),
            .last_i     (last),
            .send_ack_i (ack[g]),
            .full_o     (full[g]),
            .words_o    (buf_words[g])
        );
    end

    always_comb begin
        send_msg = '0;
        for (int i = 0; i < N_SAMPLES; i++) begin
            send_msg[BIT_WIDTH*fft_real_word(N_SAMPLES, i) +: BIT_WIDTH] =
                rd_words[BIT_WIDTH*i +: BIT_WIDTH];
        end
    end

endmodule

// File: tb/tb_fft_input_deserializer.sv
// Self-checking bench for fft_input_deserializer: frame-queue reference model
// plus directed frames with literal expectations.
module tb_fft_input_deserializer;

    localparam int BW = 32;
    localparam int N  = 8;
    localparam int FW = 2 * BW * N;
`ifdef FFT_DESER_DBUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] recv_msg = '0;
    logic          recv_val = 1'b0;
    logic          recv_rdy;
    logic [FW-1:0] send_msg;
    logic          send_val;
    logic          send_rdy = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit started = 1'b0;
    bit stream_on = 1'b0;
    int rdy_low = 0;
    int sent_cycles[$];

    logic [BW-1:0] cur[$];
    logic [FW-1:0] done[$];

    fft_input_deserializer #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int rev3(input int j);
        int r;
        r = 0;
        for (int b = 0; b < 3; b++) r = r * 2 + ((j >> b) & 1);
        return r;
    endfunction

    function automatic logic [FW-1:0] build(input logic [BW-1:0] s[$]);
        logic [FW-1:0] f;
        f = '0;
        for (int j = 0; j < N; j++) f[BW*(N + rev3(j)) +: BW] = s[j];
        return f;
    endfunction

    function automatic logic [BW-1:0] word(input logic [FW-1:0] f, input int i);
        return f[BW*i +: BW];
    endfunction

    // Reference model: compare, then advance on the transfers the model allows.
    always @(negedge clk) begin
        logic exp_rdy, exp_val, r_fire, s_fire;
        if (started) begin
            exp_val = (done.size() > 0);
            exp_rdy = (done.size() < CAP);
            check("recv_rdy", FW'(recv_rdy), FW'(exp_rdy));
            check("send_val", FW'(send_val), FW'(exp_val));
            if (exp_val) check("send_msg", send_msg, done[0]);
            if (stream_on && !recv_rdy) rdy_low++;
            if (reset) begin
                cur.delete();
                done.delete();
            end else begin
                r_fire = recv_val && exp_rdy;
                s_fire = exp_val && send_rdy;
                if (s_fire) begin
                    void'(done.pop_front());
                    sent_cycles.push_back(cyc);
                end
                if (r_fire) begin
                    cur.push_back(recv_msg);
                    if (cur.size() == N) begin
                        done.push_back(build(cur));
                        cur.delete();
                    end
                end
            end
        end
    end

    task automatic push(input logic [BW-1:0] v);
        int guard;
        guard = 0;
        recv_msg = v;
        recv_val = 1'b1;
        while (!recv_rdy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("push_timeout", FW'(1), FW'(0));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        recv_val = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int e1[8] = '{1, 5, 3, 7, 2, 6, 4, 8};
        int e3[8] = '{9, 13, 11, 15, 10, 14, 12, 16};
        logic [FW-1:0] held;
        logic [BW-1:0] neg[8];
        int gap;

        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        reset = 1'b0;
        idle(1);
        check("reset_rdy", FW'(recv_rdy), FW'(1));
        check("reset_val", FW'(send_val), FW'(0));
        check("reset_msg", send_msg, '0);

        // Frame 1..8 held by downstream for 5 cycles
        send_rdy = 1'b0;
        for (int j = 1; j <= 8; j++) push(BW'(j));
        recv_val = 1'b0;
        check("f1_val", FW'(send_val), FW'(1));
        for (int i = 0; i < 8; i++) check($sformatf("f1_real%0d", i), FW'(word(send_msg, 8 + i)), FW'(e1[i]));
        check("f1_imag", FW'(send_msg[BW*N-1:0]), '0);
        held = send_msg;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_msg", send_msg, held);
            check("hold_rdy", FW'(recv_rdy), FW'(CAP == 1 ? 0 : 1));
        end
        send_rdy = 1'b1;
        @(posedge clk); #1;
        check("after_send_val", FW'(send_val), FW'(0));
        check("after_send_rdy", FW'(recv_rdy), FW'(1));

        // recv_val toggled across a frame
        for (int j = 0; j < 8; j++) begin
            push(BW'((j + 1) << 16));
            if (j < 7) idle(1);
        end
        recv_val = 1'b0;
        check("tog_val", FW'(send_val), FW'(1));
        check("tog_slot4", FW'(word(send_msg, 8 + 4)), FW'(32'h0002_0000));
        check("tog_slot1", FW'(word(send_msg, 8 + 1)), FW'(32'h0005_0000));
        check("tog_slot7", FW'(word(send_msg, 8 + 7)), FW'(32'h0008_0000));
        idle(2);

        // Reset mid-frame
        for (int j = 0; j < 3; j++) push(BW'(100 + j));
        recv_val = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_msg", send_msg, '0);
        check("midrst_rdy", FW'(recv_rdy), FW'(1));
        check("midrst_val", FW'(send_val), FW'(0));
        send_rdy = 1'b0;
        for (int j = 9; j <= 16; j++) push(BW'(j));
        recv_val = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("rst_real%0d", i), FW'(word(send_msg, 8 + i)), FW'(e3[i]));
        send_rdy = 1'b1;
        idle(2);

        // Negative samples
        send_rdy = 1'b0;
        neg[0] = 32'hFFFF_0000;
        neg[1] = 32'h8000_0000;
        for (int j = 2; j < 8; j++) neg[j] = BW'(j);
        for (int j = 0; j < 8; j++) push(neg[j]);
        recv_val = 1'b0;
        check("neg_slot0", FW'(word(send_msg, 8 + 0)), FW'(32'hFFFF_0000));
        check("neg_slot4", FW'(word(send_msg, 8 + 4)), FW'(32'h8000_0000));
        send_rdy = 1'b1;
        idle(2);

        // Continuous stream of three frames
        sent_cycles.delete();
        rdy_low = 0;
        stream_on = 1'b1;
        for (int j = 0; j < 24; j++) push(BW'(32'h100 + j));
        recv_val = 1'b0;
        stream_on = 1'b0;
        idle(12);
        check("stream_frames", FW'(sent_cycles.size()), FW'(3));
        gap = (CAP == 2) ? N : N + 1;
        for (int k = 1; k < sent_cycles.size(); k++)
            check("stream_gap", FW'(sent_cycles[k] - sent_cycles[k-1]), FW'(gap));
        if (CAP == 2) check("stream_rdy_low", FW'(rdy_low), FW'(0));
        check("drained", FW'(done.size() + cur.size()), FW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
